// File: rtl/ana_pad_pkg.sv
// Shared types and helpers for the analog pad switch controller.
package ana_pad_pkg;

  localparam int ANA_PAD_MAX_CH = 16;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ON     = 2'd3
  } ana_pad_state_e;

  // Full-width one-hot; callers slice down to their own channel count.
  function automatic logic [ANA_PAD_MAX_CH-1:0] ana_pad_onehot(input int unsigned ch);
    logic [ANA_PAD_MAX_CH-1:0] one;
    one = {{(ANA_PAD_MAX_CH-1){1'b0}}, 1'b1};
    return one << ch;
  endfunction

endpackage

// File: rtl/ana_pad_switch_ctrl_dly_cnt.sv
// Loadable down-counter used for break, settle and dwell intervals.
module ana_pad_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ana_pad_switch_ctrl.sv
// Break-before-make analog pad switch controller with settle reporting.
// Optional autonomous channel scanning is built when ANA_PAD_SCAN_EN is defined.
module ana_pad_switch_ctrl
  import ana_pad_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CH_W          = 2,
  parameter int BBM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 8,
`ifdef ANA_PAD_SCAN_EN
  parameter int DWELL_CYCLES  = 16,
`endif
  parameter int CNT_W         = 8
) (
  input  logic            pclk,
  input  logic            n_p_reset,
  input  logic            sel_valid,
  output logic            sel_ready,
  input  logic [CH_W-1:0] sel_ch,
  input  logic            sel_off,
  input  logic            pwr_down,
`ifdef ANA_PAD_SCAN_EN
  input  logic            scan_en,
  input  logic [N_CH-1:0] scan_mask,
`endif
  output logic [N_CH-1:0] sw_en,
  output logic [CH_W-1:0] cur_ch,
  output logic            settled,
  output logic            busy,
  output logic            sel_err,
  output ana_pad_state_e  dbg_state
);

  localparam logic [CNT_W-1:0] BBM_LD    = CNT_W'(BBM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef ANA_PAD_SCAN_EN
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);
`endif

  ana_pad_state_e      state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [N_CH-1:0]     sw_en_q, sw_en_d;
  logic                settled_q, settled_d;
  logic                busy_q, busy_d;
  logic                sel_err_q, sel_err_d;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_done;
  logic                accept;
  logic                req_bad;
  logic [ANA_PAD_MAX_CH-1:0] oh_full;

  // Handshake: a request transfers on a pclk edge where sel_valid && sel_ready;
  // while valid && !ready the requester holds sel_ch/sel_off stable.
  assign sel_ready = ((state_q == ST_OFF) || (state_q == ST_ON)) && !pwr_down;
  assign accept    = sel_valid && sel_ready;
  assign req_bad   = !sel_off && (32'(sel_ch) >= N_CH);

`ifdef ANA_PAD_SCAN_EN
  logic [CH_W-1:0] nxt_ch, hi_ch, lo_ch;
  logic            hi_found, lo_found;
  logic            scan_act;

  assign scan_act = scan_en && (scan_mask != '0);

  // Next mask bit strictly above cur_ch, else the lowest set bit (wrap).
  always_comb begin
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (scan_mask[j]) begin
        if (!hi_found && (j > int'(cur_ch_q))) begin
          hi_ch    = CH_W'(j);
          hi_found = 1'b1;
        end
        if (!lo_found) begin
          lo_ch    = CH_W'(j);
          lo_found = 1'b1;
        end
      end
    end
    nxt_ch = hi_found ? hi_ch : lo_ch;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    sel_err_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = BBM_LD;
    if (pwr_down) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (accept) begin
            sel_err_d = req_bad;
            if (!sel_off && !req_bad) begin
              state_d  = ST_BREAK;
              cur_ch_d = sel_ch;
              cnt_load = 1'b1;
              cnt_val  = BBM_LD;
            end
          end
        end
        ST_BREAK: begin
          if (cnt_done) begin
            state_d  = ST_SETTLE;
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (cnt_done) begin
            state_d = ST_ON;
`ifdef ANA_PAD_SCAN_EN
            cnt_load = 1'b1;
            cnt_val  = DWELL_LD;
`endif
          end
        end
        ST_ON: begin
          if (accept) begin
            sel_err_d = req_bad;
            if (sel_off || req_bad) begin
              state_d = ST_OFF;
            end else if (sel_ch != cur_ch_q) begin
              state_d  = ST_BREAK;
              cur_ch_d = sel_ch;
              cnt_load = 1'b1;
              cnt_val  = BBM_LD;
            end else begin
`ifdef ANA_PAD_SCAN_EN
              cnt_load = 1'b1;
              cnt_val  = DWELL_LD;
`endif
            end
          end
`ifdef ANA_PAD_SCAN_EN
          else if (scan_act && cnt_done && (nxt_ch != cur_ch_q)) begin
            state_d  = ST_BREAK;
            cur_ch_d = nxt_ch;
            cnt_load = 1'b1;
            cnt_val  = BBM_LD;
          end else if (!scan_act || cnt_done) begin
            // Dwell is held at full length until scanning is active.
            cnt_load = 1'b1;
            cnt_val  = DWELL_LD;
          end
`endif
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so the switch enables never glitch.
  always_comb begin
    oh_full   = ana_pad_onehot(32'(cur_ch_d));
    sw_en_d   = ((state_d == ST_SETTLE) || (state_d == ST_ON)) ? oh_full[N_CH-1:0] : '0;
    settled_d = (state_d == ST_ON);
    busy_d    = (state_d == ST_BREAK) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state_q   <= ST_OFF;
      cur_ch_q  <= '0;
      sw_en_q   <= '0;
      settled_q <= 1'b0;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      sw_en_q   <= sw_en_d;
      settled_q <= settled_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  ana_pad_dly_cnt #(
    .CNT_W(CNT_W)
  ) u_dly_cnt (
    .clk     (pclk),
    .rst_n   (n_p_reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .done    (cnt_done)
  );

  assign sw_en     = sw_en_q;
  assign cur_ch    = cur_ch_q;
  assign settled   = settled_q;
  assign busy      = busy_q;
  assign sel_err   = sel_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ana_pad_switch_ctrl.sv
// Bench for ana_pad_switch_ctrl: directed scenarios plus random traffic against
// a timeline model (connection scheduled at accept+BBM, settled at accept+BBM+SETTLE).
module tb_ana_pad_switch_ctrl;
  import ana_pad_pkg::*;

  localparam int N_CH   = 4;
  localparam int CH_W   = 3;
  localparam int BBM    = 2;
  localparam int SETTLE = 8;
  localparam int DWELL  = 16;

  logic            pclk = 1'b0;
  logic            n_p_reset = 1'b0;
  logic            sel_valid = 1'b0;
  logic            sel_ready;
  logic [CH_W-1:0] sel_ch = '0;
  logic            sel_off = 1'b0;
  logic            pwr_down = 1'b0;
  logic [N_CH-1:0] sw_en;
  logic [CH_W-1:0] cur_ch;
  logic            settled, busy, sel_err;
  ana_pad_state_e  dbg_state;
`ifdef ANA_PAD_SCAN_EN
  logic            scan_en = 1'b0;
  logic [N_CH-1:0] scan_mask = '0;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference timeline
  int m_cur, m_conn, m_make_at, m_settle_at;
  bit m_settled, m_busy, m_pending, m_err;
  bit last_acc;

  always #5 pclk = ~pclk;

  ana_pad_switch_ctrl #(
    .N_CH(N_CH), .CH_W(CH_W), .BBM_CYCLES(BBM), .SETTLE_CYCLES(SETTLE),
`ifdef ANA_PAD_SCAN_EN
    .DWELL_CYCLES(DWELL),
`endif
    .CNT_W(8)
  ) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_ch(sel_ch), .sel_off(sel_off), .pwr_down(pwr_down),
`ifdef ANA_PAD_SCAN_EN
    .scan_en(scan_en), .scan_mask(scan_mask),
`endif
    .sw_en(sw_en), .cur_ch(cur_ch), .settled(settled), .busy(busy),
    .sel_err(sel_err), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_conn = -1; m_settled = 0; m_busy = 0; m_pending = 0; m_err = 0;
    m_make_at = 0; m_settle_at = 0;
  endtask

  task automatic model_edge(input bit acc, input int ch, input bit off, input bit pd);
    m_err = 0;
    if (pd) begin
      m_conn = -1; m_settled = 0; m_busy = 0; m_pending = 0;
    end else if (acc) begin
      if (off || ch >= N_CH) begin
        m_err = !off && (ch >= N_CH);
        m_conn = -1; m_settled = 0; m_busy = 0; m_pending = 0;
      end else if (!(m_settled && ch == m_cur)) begin
        m_cur = ch; m_conn = -1; m_settled = 0; m_busy = 1; m_pending = 1;
        m_make_at = cyc + BBM;
        m_settle_at = cyc + BBM + SETTLE;
      end
    end else if (m_pending) begin
      if (cyc == m_make_at) m_conn = m_cur;
      if (cyc == m_settle_at) begin
        m_settled = 1; m_busy = 0; m_pending = 0;
      end
    end
  endtask

  // One clock: check ready, take the edge, advance the model, compare outputs.
  task automatic step();
    bit acc;
    logic [31:0] exp_sw;
    #1;
    chk("sel_ready", 32'(sel_ready), 32'(!m_pending && !pwr_down));
    acc = sel_valid && !m_pending && !pwr_down;
    @(posedge pclk);
    cyc++;
    model_edge(acc, int'(sel_ch), sel_off, pwr_down);
    last_acc = acc;
    #1;
    exp_sw = (m_conn < 0) ? 32'd0 : (32'd1 << m_conn);
    chk("sw_en", 32'(sw_en), exp_sw);
    chk("sw_onehot", 32'($countones(sw_en) <= 1), 32'd1);
    chk("settled", 32'(settled), 32'(m_settled));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("cur_ch", 32'(cur_ch), 32'(m_cur));
  endtask

  task automatic req(input int ch, input bit off);
    sel_valid = 1'b1; sel_ch = CH_W'(ch); sel_off = off;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

`ifdef ANA_PAD_SCAN_EN
  task automatic scan_test();
    int vis[$];
    int on_len[$];
    int run;
    bit prev;
    req(0, 0);
    idle(BBM + SETTLE + 1);
    scan_mask = 4'b1011;
    scan_en = 1'b1;
    prev = settled;
    run = 0;
    for (int i = 0; i < 400 && vis.size() < 4; i++) begin
      @(posedge pclk);
      #1;
      if (settled && !prev) vis.push_back(int'(cur_ch));
      if (settled) run++;
      if (!settled && prev) begin
        on_len.push_back(run);
        run = 0;
      end
      prev = settled;
    end
    chk("scan_visits", 32'(vis.size()), 32'd4);
    if (vis.size() >= 3) begin
      chk("scan_v1", 32'(vis[0]), 32'd1);
      chk("scan_v2", 32'(vis[1]), 32'd3);
      chk("scan_v3", 32'(vis[2]), 32'd0);
    end
    if (on_len.size() >= 3) begin
      chk("dwell_1", 32'(on_len[1]), 32'(DWELL));
      chk("dwell_3", 32'(on_len[2]), 32'(DWELL));
    end
    scan_en = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    last_acc = 0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_sw_en", 32'(sw_en), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_OFF));
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge pclk);
    n_p_reset = 1'b1;

    // Connect ch2 from OFF
    req(2, 0);
    idle(BBM + SETTLE + 1);
    chk("ch2_sw", 32'(sw_en), 32'b0100);
    chk("ch2_state", 32'(dbg_state), 32'(ST_ON));

    // Switch ch2 -> ch1, then same-channel no-op
    req(1, 0);
    idle(BBM + SETTLE + 1);
    chk("ch1_sw", 32'(sw_en), 32'b0010);
    req(1, 0);
    idle(20);

    // Power-down during settle, then no reconnect after release
    req(2, 0);
    idle(BBM + 1);
    pwr_down = 1'b1;
    idle(3);
    chk("pd_state", 32'(dbg_state), 32'(ST_OFF));
    pwr_down = 1'b0;
    idle(6);
    chk("pd_stay_off", 32'(dbg_state), 32'(ST_OFF));

    // Out-of-range channel from ON
    req(3, 0);
    idle(BBM + SETTLE + 1);
    req(5, 0);
    chk("bad_state", 32'(dbg_state), 32'(ST_OFF));
    idle(2);

    // Explicit off, then async reset mid-break
    req(0, 0);
    idle(BBM + SETTLE + 1);
    req(0, 1);
    idle(2);
    req(3, 0);
    idle(1);
    #2;
    n_p_reset = 1'b0;
    #1;
    chk("arst_sw_en", 32'(sw_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cur", 32'(cur_ch), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_OFF));
    model_reset();
    @(negedge pclk);
    n_p_reset = 1'b1;
    idle(2);

    // Random traffic; a held request stays stable until accepted
    for (int it = 0; it < 600; it++) begin
      if (!sel_valid || last_acc) begin
        sel_valid = ($urandom_range(0, 3) == 0);
        sel_ch    = CH_W'($urandom_range(0, 5));
        sel_off   = ($urandom_range(0, 9) == 0);
      end
      pwr_down = ($urandom_range(0, 24) == 0);
      step();
    end
    sel_valid = 1'b0;
    pwr_down = 1'b0;
    idle(2);

`ifdef ANA_PAD_SCAN_EN
    scan_test();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
